// File: rtl/exec_controller.sv
// exec_controller: run/step/halt sequencer that owns the core enable,
// counts retired instructions and latches the display syscall value.
module exec_controller #(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        stop_req,
  input  logic        halt,
  input  logic        display_en,
  input  logic [31:0] display,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] inst_cnt,
  output logic [31:0] display_reg
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} st_t;
  st_t st, nxt;
  logic [23:0] cnt;
  logic tick;
  assign state = st;
  assign tick = st == RUN && cnt == 24'(DIV - 1);
  always_comb begin
    nxt = st;
    cpu_en = 1'b0;
    case (st)
      IDLE: nxt = run_req ? RUN : step_req ? STEP : IDLE;
      RUN: begin
        cpu_en = tick & ~halt & ~stop_req;
        nxt = stop_req ? IDLE : (tick & halt) ? HALT : RUN;
      end
      STEP: begin
        cpu_en = ~halt & ~stop_req;
        nxt = (halt & ~stop_req) ? HALT : IDLE;
      end
      HALT: begin
        // resume forces the pending syscall to retire regardless of halt
        cpu_en = (run_req | step_req) & ~stop_req;
        nxt = stop_req ? IDLE : run_req ? RUN : step_req ? IDLE : HALT;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      halted <= 1'b0;
      inst_cnt <= '0;
      display_reg <= '0;
    end else begin
      st <= nxt;
      cnt <= (st == RUN && nxt == RUN && !tick) ? cnt + 24'd1 : '0;
      halted <= nxt == HALT;
      if (cpu_en) inst_cnt <= inst_cnt + 32'd1;
      if (cpu_en & display_en) display_reg <= display;
    end
  end
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: scoreboard bench; stimulus queues expected retires, a monitor checks each cpu_en pulse.
module tb_exec_controller;
  logic clk = 0, rst1_n = 0, rst4_n = 0;
  logic run_req = 0, step_req = 0, stop_req = 0, halt = 0, display_en = 0;
  logic [31:0] display = 0;
  logic cpu_en1, cpu_en4, halted1, halted4;
  logic [1:0] state1, state4;
  logic [31:0] inst_cnt1, inst_cnt4, display_reg1, display_reg4;
  int total = 0, passed = 0;
  typedef struct {logic [31:0] cnt; logic [1:0] st;} exp_t;
  exp_t q1[$], q4[$];

  always #5 clk = ~clk;

  exec_controller #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .halt(halt), .display_en(display_en), .display(display), .cpu_en(cpu_en1), .state(state1),
    .halted(halted1), .inst_cnt(inst_cnt1), .display_reg(display_reg1)
  );
  exec_controller #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .halt(halt), .display_en(display_en), .display(display), .cpu_en(cpu_en4), .state(state4),
    .halted(halted4), .inst_cnt(inst_cnt4), .display_reg(display_reg4)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cpu_en1) begin
      if (q1.size() == 0) chk("dut1 unexpected retire", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 retire inst_cnt", inst_cnt1, e.cnt);
        chk("dut1 retire state", 32'(state1), 32'(e.st));
      end
    end
    if (cpu_en4) begin
      if (q4.size() == 0) chk("dut4 unexpected retire", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("dut4 retire inst_cnt", inst_cnt4, e.cnt);
        chk("dut4 retire state", 32'(state4), 32'(e.st));
      end
    end
  end

  initial begin
    repeat (2) cyc();
    chk("reset state", 32'(state1), 0);
    chk("reset inst_cnt", inst_cnt1, 0);
    chk("reset display_reg", display_reg1, 0);
    chk("reset cpu_en", 32'(cpu_en1), 0);
    rst1_n = 1;
    cyc();
    // three single steps, each retiring one cycle after its request
    for (int k = 0; k < 3; k++) begin
      q1.push_back('{32'(k), 2'd2});
      step_req = 1;
      cyc();
      step_req = 0;
      repeat (3) cyc();
    end
    chk("step inst_cnt", inst_cnt1, 3);
    chk("step state", 32'(state1), 0);
    // DIV=1 run, halt presented on the 6th instruction
    for (int k = 3; k < 8; k++) q1.push_back('{32'(k), 2'd1});
    run_req = 1;
    step_req = 1;
    cyc();
    run_req = 0;
    step_req = 0;
    chk("run beats step", 32'(state1), 1);
    repeat (5) cyc();
    halt = 1;
    #1 chk("halt cpu_en", 32'(cpu_en1), 0);
    cyc();
    chk("halt state", 32'(state1), 3);
    chk("halted", 32'(halted1), 1);
    chk("halt inst_cnt", inst_cnt1, 8);
    q1.push_back('{32'd8, 2'd3});
    step_req = 1;
    #1 chk("halt step cpu_en", 32'(cpu_en1), 1);
    cyc();
    step_req = 0;
    halt = 0;
    chk("resume inst_cnt", inst_cnt1, 9);
    chk("resume state", 32'(state1), 0);
    chk("resume halted", 32'(halted1), 0);
    // display latch, then halt wins over display
    q1.push_back('{32'd9, 2'd1});
    run_req = 1;
    cyc();
    run_req = 0;
    display_en = 1;
    display = 32'h12345678;
    cyc();
    chk("display load", display_reg1, 32'h12345678);
    halt = 1;
    display = 32'hDEADBEEF;
    cyc();
    chk("halt blocks display", display_reg1, 32'h12345678);
    chk("halt+display state", 32'(state1), 3);
    chk("halt+display inst_cnt", inst_cnt1, 10);
    display_en = 0;
    stop_req = 1;
    run_req = 1;
    #1 chk("stop+run cpu_en", 32'(cpu_en1), 0);
    cyc();
    stop_req = 0;
    run_req = 0;
    chk("stop+run state", 32'(state1), 0);
    chk("stop+run inst_cnt", inst_cnt1, 10);
    // halt again, then run resume with display load on the forced retire
    run_req = 1;
    cyc();
    run_req = 0;
    cyc();
    chk("rehalt state", 32'(state1), 3);
    q1.push_back('{32'd10, 2'd3});
    run_req = 1;
    display_en = 1;
    display = 32'hCAFEF00D;
    cyc();
    run_req = 0;
    display_en = 0;
    halt = 0;
    stop_req = 1;
    chk("forced retire display", display_reg1, 32'hCAFEF00D);
    chk("forced retire state", 32'(state1), 1);
    chk("forced retire inst_cnt", inst_cnt1, 11);
    cyc();
    stop_req = 0;
    chk("stop from run", 32'(state1), 0);
    // counter wrap
    force dut1.inst_cnt = 32'hFFFFFFFF;
    #1 release dut1.inst_cnt;
    #1 chk("preload inst_cnt", inst_cnt1, 32'hFFFFFFFF);
    q1.push_back('{32'hFFFFFFFF, 2'd2});
    step_req = 1;
    cyc();
    step_req = 0;
    cyc();
    chk("wrap inst_cnt", inst_cnt1, 0);
    // async reset mid-run
    q1.push_back('{32'd0, 2'd1});
    q1.push_back('{32'd1, 2'd1});
    run_req = 1;
    cyc();
    run_req = 0;
    repeat (2) cyc();
    #2 rst1_n = 0;
    #1;
    chk("async rst cpu_en", 32'(cpu_en1), 0);
    chk("async rst state", 32'(state1), 0);
    chk("async rst inst_cnt", inst_cnt1, 0);
    chk("async rst display_reg", display_reg1, 0);
    @(negedge clk);
    rst1_n = 1;
    repeat (3) cyc();
    chk("post rst idle inst_cnt", inst_cnt1, 0);
    // DIV=4 run on the second instance; first held in reset
    rst1_n = 0;
    rst4_n = 1;
    cyc();
    for (int k = 0; k < 5; k++) q4.push_back('{32'(k), 2'd1});
    run_req = 1;
    cyc();
    run_req = 0;
    repeat (23) cyc();
    stop_req = 1;
    #1 chk("div4 stop cpu_en", 32'(cpu_en4), 0);
    chk("div4 inst_cnt", inst_cnt4, 5);
    cyc();
    stop_req = 0;
    chk("div4 stop state", 32'(state4), 0);
    chk("div4 final inst_cnt", inst_cnt4, 5);
    cyc();
    chk("q1 drained", q1.size(), 0);
    chk("q4 drained", q4.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Run/step/halt sequencer for the single-cycle CPU core. It is the only source of the core's `en`.
- It turns user run/step/stop pulses into instruction-retire enables, with optional slow-run division for visible on-board execution.
- On a halting syscall it parks the core and resumes on request.
- It counts retired instructions and latches the syscall-34 display value. It sits between the I/O top module and the CPU core.

Parameters:
- DIV, 1, RUN-mode retire period in clk cycles (1 = every cycle); legal range 1..2^24.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- run_req  in  1  single-cycle pulse (already synchronized/debounced): enter continuous run
- step_req  in  1  pulse: execute exactly one instruction
- stop_req  in  1  pulse: return to IDLE
- halt  in  1  from core syscall unit; combinational for the instruction currently presented
- display_en  in  1  from core syscall unit; current instruction is a display syscall
- display  in  32  value to display from core
- cpu_en  out  1  core enable; 1 = current instruction retires this cycle
- state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
- halted  out  1  state==HALT
- inst_cnt  out  32  retired-instruction count
- display_reg  out  32  last displayed value

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, tick counter=0, inst_cnt=0, display_reg=0.
  - cpu_en=0 immediately, including mid-RUN or mid-STEP; no partial retire.
- Request priority when pulses coincide: stop_req > run_req > step_req.
- Tick counter, RUN only:
  - Counts 0..DIV-1 and wraps. tick = (counter==DIV-1).
  - Cleared to 0 on every entry to RUN.
  - With DIV=1, tick is always 1.
- cpu_en is combinational from registered state and the same-cycle inputs:
  - IDLE: 0.
  - RUN: tick & ~halt & ~stop_req.
  - STEP: ~halt & ~stop_req.
  - HALT: (run_req | step_req) & ~stop_req. This forced retire ignores halt, so the syscall instruction completes and PC moves on.
- Transitions, evaluated at each rising clk edge:
  - IDLE: run_req -> RUN; else step_req -> STEP; stop_req has no effect.
  - RUN: stop_req -> IDLE; else tick & halt -> HALT; else stay. Requests to run or step are ignored.
  - STEP: stop_req -> IDLE with no retire; else halt -> HALT; else retire -> IDLE. Always leaves STEP after exactly one cycle.
  - HALT: stop_req -> IDLE with no retire (syscall stays pending); else run_req -> RUN with retire; else step_req -> IDLE with retire.
- Halt detection only happens on a cycle where the instruction would otherwise retire (RUN with tick, or STEP). When halt is detected, cpu_en=0 in that cycle.
- inst_cnt:
  - +1 at every clk edge where cpu_en=1.
  - Wraps 0xFFFFFFFF -> 0 silently.
- display_reg:
  - Loads display at the edge where cpu_en & display_en.
  - Otherwise it holds.
  - If halt and display_en are both 1 in RUN/STEP, halt wins: no retire, no load.
  - A HALT-state forced retire does load display_reg if display_en=1.
- Latency: a request in IDLE produces its first retire in the next cycle (RUN with DIV=1, or STEP). A resume from HALT retires in the request cycle itself.
- Registered outputs: state, halted, inst_cnt, display_reg. cpu_en is the only combinational output.

Test Plan:
- Reset, then step_req ×3 spaced by 4 cycles, halt=0 -> exactly 3 cycles with cpu_en=1, each one cycle after its request; inst_cnt=3; state returns to 0.
- DIV=4, run_req, hold 20 cycles -> cpu_en high on cycles 4, 8, 12, 16, 20 after entry; inst_cnt=5. Then stop_req -> state=0 next edge, no retire on the stop cycle.
- RUN with DIV=1, halt=1 on the 6th instruction -> cpu_en=0 that cycle; state=3 and halted=1 next edge; inst_cnt=5. Then step_req -> cpu_en=1 same cycle, inst_cnt=6, state=0.
- RUN with display_en=1 and display=0x12345678 on a tick -> display_reg=0x12345678 next edge. With halt=1 and display_en=1 together -> display_reg unchanged, state=3.
- In HALT, stop_req and run_req in the same cycle -> cpu_en=0, state=0. Preload inst_cnt to 0xFFFFFFFF via 2^32-1 retires (or force), then one retire -> inst_cnt=0.
- rst_n dropped mid-RUN, asynchronous to clk -> cpu_en, state, inst_cnt and display_reg go to 0 before the next clk edge. After release, no retire occurs until a request arrives.
